route_lpm_tcam: RTL and testbench

- Parametrised, pipelined longest-prefix-match TCAM for next-hop route lookup.
- Next generation of the existing route lookup block. Adds:
  - per-entry valid bits
  - prefix length computed and stored at write time
  - default-route (/0) hits
  - explicit hit/miss output
  - valid/ready handshake with backpressure
  - hit/miss statistics counters
- Sits between header parser and forwarding/egress selection; the management path writes routes concurrently with lookups.

---
 rtl/route_lpm_tcam_pkg.sv | 42 ++++
 rtl/route_lpm_tcam_if.sv | 36 +++
 rtl/route_lpm_tcam_prio_select.sv | 64 ++++++
 rtl/route_lpm_tcam.sv | 170 +++++++++++++++++
 tb/tb_route_lpm_tcam.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/route_lpm_tcam_pkg.sv
`default_nettype none
// ============================================================================
// Module   : route_pkg
// Brief    : Shared widths, entry/result types and popcount for route_lpm_tcam
// Revision : 1.0
// ============================================================================
package route_pkg;

  localparam int c_ADDR_W_DEF  = 32;
  localparam int c_ENTRIES_DEF = 16;
  localparam int c_IF_W_DEF    = 4;
  localparam int c_CNT_W_DEF   = 32;
  localparam int c_IDX_W_DEF   = $clog2(c_ENTRIES_DEF);
  localparam int c_LEN_W_DEF   = $clog2(c_ADDR_W_DEF + 1);

  typedef struct packed {
    logic                    valid;
    logic [c_ADDR_W_DEF-1:0] prefix;
    logic [c_ADDR_W_DEF-1:0] mask;
    logic [c_LEN_W_DEF-1:0]  len;
    logic [c_ADDR_W_DEF-1:0] next_hop;
    logic [c_IF_W_DEF-1:0]   if_idx;
  } route_entry_t;

  typedef struct packed {
    logic                    hit;
    logic [c_ADDR_W_DEF-1:0] next_hop;
    logic [c_IF_W_DEF-1:0]   if_idx;
    logic [c_LEN_W_DEF-1:0]  prefix_len;
    logic [c_IDX_W_DEF-1:0]  index;
  } lookup_result_t;

  // Masks up to 64 bits wide; callers zero-extend and truncate the count.
  function automatic logic [6:0] popcount(input logic [63:0] v);
    logic [6:0] n;
    n = '0;
    for (int i = 0; i < 64; i++) n = n + {6'd0, v[i]};
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/route_lpm_tcam_if.sv
`default_nettype none
// ============================================================================
// Module   : route_lpm_tcam_if
// Brief    : Lookup request / result handshake bundle for route_lpm_tcam
// Revision : 1.0
// ============================================================================
interface route_lpm_tcam_if #(
  parameter int ADDR_W = 32,
  parameter int IF_W   = 4,
  parameter int IDX_W  = 4,
  parameter int LEN_W  = 6
);
  logic              lkp_valid;
  logic              lkp_ready;
  logic [ADDR_W-1:0] lkp_addr;
  logic              res_valid;
  logic              res_ready;
  logic              res_hit;
  logic [ADDR_W-1:0] res_next_hop;
  logic [IF_W-1:0]   res_if_idx;
  logic [LEN_W-1:0]  res_prefix_len;
  logic [IDX_W-1:0]  res_index;

  modport master (
    output lkp_valid, lkp_addr, res_ready,
    input  lkp_ready, res_valid, res_hit, res_next_hop, res_if_idx,
           res_prefix_len, res_index
  );

  modport slave (
    input  lkp_valid, lkp_addr, res_ready,
    output lkp_ready, res_valid, res_hit, res_next_hop, res_if_idx,
           res_prefix_len, res_index
  );
endinterface
`default_nettype wire

// File: rtl/route_lpm_tcam_prio_select.sv
`default_nettype none
// ============================================================================
// Module   : lpm_prio_select
// Brief    : Combinational argmax tree over matching entries, lowest index wins ties
// Revision : 1.0
// ============================================================================
module lpm_prio_select #(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = 4,
  parameter int LEN_W   = 6
) (
  input  logic [ENTRIES-1:0]            match,
  input  logic [ENTRIES-1:0][LEN_W-1:0] len,
  output logic                          hit,
  output logic [IDX_W-1:0]              index,
  output logic [LEN_W-1:0]              best_len
);

  localparam int c_LEAVES = 1 << IDX_W;

  logic [c_LEAVES-1:0]       w_match_pad;
  logic [c_LEAVES*LEN_W-1:0] w_len_pad;
  logic [c_LEAVES-1:0]       w_lv_v [IDX_W+1];
  logic [IDX_W-1:0]          w_lv_i [IDX_W+1][c_LEAVES];
  logic [LEN_W-1:0]          w_lv_l [IDX_W+1][c_LEAVES];

  assign w_match_pad = c_LEAVES'(match);
  assign w_len_pad   = (c_LEAVES*LEN_W)'(len);

  // Left child always holds the lower indices, so only a strictly longer right wins.
  always_comb begin
    for (int l = 0; l <= IDX_W; l++) begin
      w_lv_v[l] = '0;
      for (int k = 0; k < c_LEAVES; k++) begin
        w_lv_i[l][k] = '0;
        w_lv_l[l][k] = '0;
      end
    end
    for (int k = 0; k < c_LEAVES; k++) begin
      w_lv_v[0][k] = w_match_pad[k];
      w_lv_i[0][k] = IDX_W'(k);
      w_lv_l[0][k] = w_len_pad[k*LEN_W +: LEN_W];
    end
    for (int l = 0; l < IDX_W; l++) begin
      for (int k = 0; k < (c_LEAVES >> (l + 1)); k++) begin
        if (w_lv_v[l][2*k+1] &&
            (!w_lv_v[l][2*k] || (w_lv_l[l][2*k+1] > w_lv_l[l][2*k]))) begin
          w_lv_i[l+1][k] = w_lv_i[l][2*k+1];
          w_lv_l[l+1][k] = w_lv_l[l][2*k+1];
        end else begin
          w_lv_i[l+1][k] = w_lv_i[l][2*k];
          w_lv_l[l+1][k] = w_lv_l[l][2*k];
        end
        w_lv_v[l+1][k] = w_lv_v[l][2*k] | w_lv_v[l][2*k+1];
      end
    end
  end

  assign hit      = w_lv_v[IDX_W][0];
  assign index    = w_lv_i[IDX_W][0];
  assign best_len = w_lv_l[IDX_W][0];

endmodule
`default_nettype wire

// File: rtl/route_lpm_tcam.sv
`default_nettype none
// ============================================================================
// Module   : route_lpm_tcam
// Brief    : Two-stage pipelined longest-prefix-match route TCAM with stats
// Revision : 1.0
// ============================================================================
module route_lpm_tcam
  import route_pkg::*;
#(
  parameter  int ADDR_W  = c_ADDR_W_DEF,
  parameter  int ENTRIES = c_ENTRIES_DEF,
  parameter  int IF_W    = c_IF_W_DEF,
  parameter  int CNT_W   = c_CNT_W_DEF,
  localparam int IDX_W   = $clog2(ENTRIES),
  localparam int LEN_W   = $clog2(ADDR_W + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  route_lpm_tcam_if.slave   lkp,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_index,
  input  logic              wr_entry_valid,
  input  logic [ADDR_W-1:0] wr_prefix,
  input  logic [ADDR_W-1:0] wr_mask,
  input  logic [ADDR_W-1:0] wr_next_hop,
  input  logic [IF_W-1:0]   wr_if_idx,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  logic              r_valid  [ENTRIES];
  logic [ADDR_W-1:0] r_prefix [ENTRIES];
  logic [ADDR_W-1:0] r_mask   [ENTRIES];
  logic [LEN_W-1:0]  r_len    [ENTRIES];
  logic [ADDR_W-1:0] r_nh     [ENTRIES];
  logic [IF_W-1:0]   r_if     [ENTRIES];

  logic [ENTRIES-1:0]            w_match;
  logic [LEN_W-1:0]              w_wr_len;
  logic                          w_stall;
  logic                          w_xfer;

  logic                          r_s1_valid;
  logic [ENTRIES-1:0]            r_s1_match;
  logic [ENTRIES-1:0][LEN_W-1:0] r_s1_len;
  logic [ADDR_W-1:0]             r_s1_nh [ENTRIES];
  logic [IF_W-1:0]               r_s1_if [ENTRIES];

  logic                          w_sel_hit;
  logic [IDX_W-1:0]              w_sel_idx;
  logic [LEN_W-1:0]              w_sel_len;

  logic                          r_res_valid;
  logic                          r_res_hit;
  logic [ADDR_W-1:0]             r_res_nh;
  logic [IF_W-1:0]               r_res_if;
  logic [LEN_W-1:0]              r_res_len;
  logic [IDX_W-1:0]              r_res_idx;

  assign w_wr_len = LEN_W'(popcount(64'(wr_mask)));
  assign w_stall  = r_res_valid & ~lkp.res_ready;
  assign w_xfer   = r_res_valid & lkp.res_ready;

  // Indices at or beyond ENTRIES never decode to any entry, so such writes fall away.
  for (genvar e = 0; e < ENTRIES; e++) begin : g_entry
    logic w_sel;
    assign w_sel      = wr_en && (wr_index == IDX_W'(e));
    assign w_match[e] = r_valid[e] && ((lkp.lkp_addr & r_mask[e]) == r_prefix[e]);

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_valid[e]  <= 1'b0;
        r_prefix[e] <= '0;
        r_mask[e]   <= '0;
        r_len[e]    <= '0;
        r_nh[e]     <= '0;
        r_if[e]     <= '0;
      end else if (w_sel) begin
        r_valid[e]  <= wr_entry_valid;
        r_prefix[e] <= wr_prefix & wr_mask;
        r_mask[e]   <= wr_mask;
        r_len[e]    <= w_wr_len;
        r_nh[e]     <= wr_next_hop;
        r_if[e]     <= wr_if_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_match <= '0;
    end else if (!w_stall) begin
      r_s1_valid <= lkp.lkp_valid;
      if (lkp.lkp_valid) r_s1_match <= w_match;
    end
  end

  // Per-entry snapshot keeps in-flight results immune to later table writes.
  always_ff @(posedge clk) begin
    if (!w_stall && lkp.lkp_valid) begin
      for (int e = 0; e < ENTRIES; e++) begin
        r_s1_len[e] <= r_len[e];
        r_s1_nh[e]  <= r_nh[e];
        r_s1_if[e]  <= r_if[e];
      end
    end
  end

  lpm_prio_select #(
    .ENTRIES (ENTRIES),
    .IDX_W   (IDX_W),
    .LEN_W   (LEN_W)
  ) u_prio (
    .match    (r_s1_match),
    .len      (r_s1_len),
    .hit      (w_sel_hit),
    .index    (w_sel_idx),
    .best_len (w_sel_len)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_res_valid <= 1'b0;
      r_res_hit   <= 1'b0;
      r_res_nh    <= '0;
      r_res_if    <= '0;
      r_res_len   <= '0;
      r_res_idx   <= '0;
    end else if (!w_stall) begin
      r_res_valid <= r_s1_valid;
      if (r_s1_valid && w_sel_hit) begin
        r_res_hit <= 1'b1;
        r_res_nh  <= r_s1_nh[w_sel_idx];
        r_res_if  <= r_s1_if[w_sel_idx];
        r_res_len <= w_sel_len;
        r_res_idx <= w_sel_idx;
      end else begin
        r_res_hit <= 1'b0;
        r_res_nh  <= '0;
        r_res_if  <= '0;
        r_res_len <= '0;
        r_res_idx <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (w_xfer) begin
      if (r_res_hit) begin
        if (hit_cnt != '1) hit_cnt <= hit_cnt + 1'b1;
      end else begin
        if (miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
      end
    end
  end

  assign lkp.lkp_ready      = ~w_stall;
  assign lkp.res_valid      = r_res_valid;
  assign lkp.res_hit        = r_res_hit;
  assign lkp.res_next_hop   = r_res_nh;
  assign lkp.res_if_idx     = r_res_if;
  assign lkp.res_prefix_len = r_res_len;
  assign lkp.res_index      = r_res_idx;

endmodule
`default_nettype wire

// File: tb/tb_route_lpm_tcam.sv
`default_nettype none
// ============================================================================
// Module   : tb_route_lpm_tcam
// Brief    : Directed self-checking bench for route_lpm_tcam (CNT_W = 4 build)
// Revision : 1.0
// ============================================================================
module tb_route_lpm_tcam;

  localparam int ADDR_W  = 32;
  localparam int ENTRIES = 16;
  localparam int IF_W    = 4;
  localparam int CNT_W   = 4;
  localparam int IDX_W   = 4;
  localparam int LEN_W   = 6;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              wr_en = 1'b0;
  logic [IDX_W-1:0]  wr_index = '0;
  logic              wr_entry_valid = 1'b0;
  logic [ADDR_W-1:0] wr_prefix = '0;
  logic [ADDR_W-1:0] wr_mask = '0;
  logic [ADDR_W-1:0] wr_next_hop = '0;
  logic [IF_W-1:0]   wr_if_idx = '0;
  logic [CNT_W-1:0]  hit_cnt;
  logic [CNT_W-1:0]  miss_cnt;

  int n_checks = 0;
  int n_errors = 0;

  route_lpm_tcam_if #(.ADDR_W(ADDR_W), .IF_W(IF_W), .IDX_W(IDX_W), .LEN_W(LEN_W)) lkp_if ();

  route_lpm_tcam #(.ADDR_W(ADDR_W), .ENTRIES(ENTRIES), .IF_W(IF_W), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .lkp            (lkp_if.slave),
    .wr_en          (wr_en),
    .wr_index       (wr_index),
    .wr_entry_valid (wr_entry_valid),
    .wr_prefix      (wr_prefix),
    .wr_mask        (wr_mask),
    .wr_next_hop    (wr_next_hop),
    .wr_if_idx      (wr_if_idx),
    .hit_cnt        (hit_cnt),
    .miss_cnt       (miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_res(input string tag, input logic hit, input int idx, input int len,
                           input logic [31:0] nh, input int ifx);
    check_eq({tag, ".valid"}, 64'(lkp_if.res_valid), 64'd1);
    check_eq({tag, ".hit"},   64'(lkp_if.res_hit), 64'(hit));
    check_eq({tag, ".idx"},   64'(lkp_if.res_index), 64'(idx));
    check_eq({tag, ".len"},   64'(lkp_if.res_prefix_len), 64'(len));
    check_eq({tag, ".nh"},    64'(lkp_if.res_next_hop), 64'(nh));
    check_eq({tag, ".if"},    64'(lkp_if.res_if_idx), 64'(ifx));
  endtask

  task automatic check_cnt(input string tag, input int hits, input int misses);
    check_eq({tag, ".hit_cnt"},  64'(hit_cnt), 64'(hits));
    check_eq({tag, ".miss_cnt"}, 64'(miss_cnt), 64'(misses));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    lkp_if.lkp_valid = 1'b0;
    lkp_if.res_ready = 1'b1;
    wr_en = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic write_entry(input int idx, input logic v, input logic [31:0] prefix,
                             input logic [31:0] mask, input logic [31:0] nh, input int ifx);
    wr_en = 1'b1;
    wr_index = IDX_W'(idx);
    wr_entry_valid = v;
    wr_prefix = prefix;
    wr_mask = mask;
    wr_next_hop = nh;
    wr_if_idx = IF_W'(ifx);
    tick();
    wr_en = 1'b0;
  endtask

  // Accept, confirm nothing after one edge, check the result after the second, then drain.
  task automatic lookup_expect(input string tag, input logic [31:0] addr, input logic hit,
                               input int idx, input int len, input logic [31:0] nh, input int ifx);
    check_eq({tag, ".ready"}, 64'(lkp_if.lkp_ready), 64'd1);
    lkp_if.lkp_valid = 1'b1;
    lkp_if.lkp_addr = addr;
    tick();
    lkp_if.lkp_valid = 1'b0;
    check_eq({tag, ".early"}, 64'(lkp_if.res_valid), 64'd0);
    tick();
    check_res(tag, hit, idx, len, nh, ifx);
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    lkp_if.lkp_valid = 1'b0;
    lkp_if.lkp_addr = '0;
    lkp_if.res_ready = 1'b1;
    #1;
    do_reset();

    check_eq("rst.res_valid", 64'(lkp_if.res_valid), 64'd0);
    check_eq("rst.res_hit", 64'(lkp_if.res_hit), 64'd0);
    check_eq("rst.res_nh", 64'(lkp_if.res_next_hop), 64'd0);
    check_eq("rst.lkp_ready", 64'(lkp_if.lkp_ready), 64'd1);
    check_cnt("rst", 0, 0);

    lookup_expect("t1.miss", 32'h0A000001, 1'b0, 0, 0, 32'h0, 0);
    check_cnt("t1", 0, 1);

    write_entry(0, 1'b1, 32'h00000000, 32'h00000000, 32'hC0A80001, 1);
    write_entry(3, 1'b1, 32'h0A000000, 32'hFF000000, 32'h0A0000FE, 2);
    write_entry(5, 1'b1, 32'h0A010000, 32'hFFFF0000, 32'h0A0100FE, 3);
    lookup_expect("t2.l16", 32'h0A010203, 1'b1, 5, 16, 32'h0A0100FE, 3);
    lookup_expect("t2.l8",  32'h0A020000, 1'b1, 3, 8,  32'h0A0000FE, 2);
    lookup_expect("t2.def", 32'h0B000001, 1'b1, 0, 0,  32'hC0A80001, 1);
    check_cnt("t2", 3, 1);

    // Invalidate e5 on the very edge the lookup is accepted.
    lkp_if.lkp_valid = 1'b1;
    lkp_if.lkp_addr = 32'h0A010203;
    wr_en = 1'b1;
    wr_index = 4'd5;
    wr_entry_valid = 1'b0;
    wr_prefix = 32'h0A010000;
    wr_mask = 32'hFFFF0000;
    wr_next_hop = 32'h0A0100FE;
    wr_if_idx = 4'd3;
    tick();
    lkp_if.lkp_valid = 1'b0;
    wr_en = 1'b0;
    tick();
    check_res("t5.same_edge", 1'b1, 5, 16, 32'h0A0100FE, 3);
    tick();
    lookup_expect("t5.after", 32'h0A010203, 1'b1, 3, 8, 32'h0A0000FE, 2);

    write_entry(5, 1'b1, 32'h0A010000, 32'hFFFF0000, 32'h0A0100FE, 3);
    lkp_if.res_ready = 1'b0;
    lkp_if.lkp_valid = 1'b1;
    lkp_if.lkp_addr = 32'h0A010203;
    tick();
    tick();
    lkp_if.lkp_valid = 1'b0;
    check_eq("t5.stalled", 64'(lkp_if.lkp_ready), 64'd0);
    write_entry(5, 1'b0, 32'h0A010000, 32'hFFFF0000, 32'h0A0100FE, 3);
    check_res("t5.held_a", 1'b1, 5, 16, 32'h0A0100FE, 3);
    lkp_if.res_ready = 1'b1;
    tick();
    check_res("t5.held_b", 1'b1, 5, 16, 32'h0A0100FE, 3);
    tick();
    check_eq("t5.drained", 64'(lkp_if.res_valid), 64'd0);
    check_cnt("t5", 7, 1);

    do_reset();
    write_entry(2, 1'b1, 32'h0A000000, 32'hFF000000, 32'h0A000002, 5);
    write_entry(7, 1'b1, 32'h0A000000, 32'hFF000000, 32'h0A000007, 6);
    lookup_expect("t3.tie", 32'h0A000005, 1'b1, 2, 8, 32'h0A000002, 5);
    write_entry(2, 1'b0, 32'h0A000000, 32'hFF000000, 32'h0A000002, 5);
    write_entry(7, 1'b0, 32'h0A000000, 32'hFF000000, 32'h0A000007, 6);
    write_entry(15, 1'b1, 32'hC0A80000, 32'hFFFFFF00, 32'hC0A800FE, 7);
    lookup_expect("t3.last", 32'hC0A80007, 1'b1, 15, 24, 32'hC0A800FE, 7);
    lookup_expect("t3.inval", 32'h0A000005, 1'b0, 0, 0, 32'h0, 0);
    write_entry(4, 1'b1, 32'h0A0000FF, 32'hFF000000, 32'h0A0000AA, 4);
    lookup_expect("t3.masked", 32'h0A123456, 1'b1, 4, 8, 32'h0A0000AA, 4);
    check_cnt("t3", 3, 1);

    lkp_if.res_ready = 1'b0;
    lkp_if.lkp_valid = 1'b1;
    lkp_if.lkp_addr = 32'h0A000001;
    check_eq("t4.acc0", 64'(lkp_if.lkp_ready), 64'd1);
    tick();
    lkp_if.lkp_addr = 32'hC0A80001;
    check_eq("t4.acc1", 64'(lkp_if.lkp_ready), 64'd1);
    tick();
    lkp_if.lkp_addr = 32'h01020304;
    check_eq("t4.full", 64'(lkp_if.lkp_ready), 64'd0);
    check_res("t4.x0", 1'b1, 4, 8, 32'h0A0000AA, 4);
    repeat (3) tick();
    check_eq("t4.full2", 64'(lkp_if.lkp_ready), 64'd0);
    check_res("t4.x1", 1'b1, 4, 8, 32'h0A0000AA, 4);
    lkp_if.res_ready = 1'b1;
    tick();
    lkp_if.lkp_valid = 1'b0;
    check_res("t4.y", 1'b1, 15, 24, 32'hC0A800FE, 7);
    tick();
    check_res("t4.z", 1'b0, 0, 0, 32'h0, 0);
    tick();
    check_eq("t4.empty", 64'(lkp_if.res_valid), 64'd0);
    check_cnt("t4", 5, 2);

    do_reset();
    lkp_if.lkp_valid = 1'b1;
    lkp_if.lkp_addr = 32'h01010101;
    repeat (17) tick();
    lkp_if.lkp_valid = 1'b0;
    repeat (2) tick();
    check_eq("t6.empty", 64'(lkp_if.res_valid), 64'd0);
    check_cnt("t6.sat", 0, 15);
    lkp_if.lkp_valid = 1'b1;
    repeat (2) tick();
    check_eq("t6.busy", 64'(lkp_if.res_valid), 64'd1);
    rst_n = 1'b0;
    lkp_if.lkp_valid = 1'b0;
    tick();
    check_eq("t6.rst_valid", 64'(lkp_if.res_valid), 64'd0);
    check_cnt("t6.rst", 0, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("t6.no_stale", 64'(lkp_if.res_valid), 64'd0);
    end
    check_cnt("t6.end", 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
